// File: rtl/led_fade_if.sv
// Control/observation bundle between the blink logic and the LED fade stage.
// The master drives the request and brightness; the slave returns pad drive and status.
interface led_fade_if #(
  parameter int PWM_BITS = 8
);
  logic                led_in;
  logic                enable;
  logic [PWM_BITS-1:0] max_duty;
  logic                led_out;
  logic [PWM_BITS-1:0] duty;
  logic                busy;

  modport master (output led_in, enable, max_duty, input led_out, duty, busy);
  modport slave  (input led_in, enable, max_duty, output led_out, duty, busy);
endinterface

// File: rtl/led_fade_pwm.sv
// LED PWM driver that fades between off and max_duty using a linear duty ramp.
// state     | meaning
// OFF       | duty held at 0, waiting for a request
// RAMP_UP   | duty rising one LSB every RAMP_PERIOD cycles toward max_duty
// ON        | duty tracks max_duty live
// RAMP_DOWN | duty falling one LSB every RAMP_PERIOD cycles toward 0
module led_fade_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_PERIOD = 16
) (
  input logic      clk,
  input logic      rst,
  led_fade_if.slave bus
);
  localparam int TW = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(RAMP_PERIOD - 1);

  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                led_out_q;
  logic                req;
  logic [PWM_BITS:0]   duty_inc;

  assign req      = bus.led_in & bus.enable;
  assign duty_inc = {1'b0, duty_q} + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      duty_q    <= '0;
      tmr_q     <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      tmr_q     <= tmr_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      led_out_q <= (pwm_cnt_q < duty_q);
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tmr_d   = tmr_q;
    case (state_q)
      OFF: begin
        duty_d = '0;
        if (req) begin
          state_d = RAMP_UP;
          tmr_d   = '0;
        end
      end
      RAMP_UP: begin
        if (!req) begin
          state_d = RAMP_DOWN;
          tmr_d   = '0;
        end else if (duty_q >= bus.max_duty) begin
          // max_duty lowered below the ramp: snap without waiting for a step
          duty_d  = bus.max_duty;
          state_d = ON;
        end else if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (duty_inc >= {1'b0, bus.max_duty}) begin
            duty_d  = bus.max_duty;
            state_d = ON;
          end else begin
            duty_d = duty_inc[PWM_BITS-1:0];
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ON: begin
        duty_d = bus.max_duty;
        if (!req) begin
          state_d = RAMP_DOWN;
          tmr_d   = '0;
        end
      end
      RAMP_DOWN: begin
        if (req) begin
          state_d = RAMP_UP;
          tmr_d   = '0;
        end else if (duty_q == '0) begin
          state_d = OFF;
        end else if (tmr_q == TMR_LAST) begin
          tmr_d  = '0;
          duty_d = duty_q - 1'b1;
          if (duty_q == PWM_BITS'(1)) state_d = OFF;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign bus.led_out = led_out_q;
  assign bus.duty    = duty_q;
  assign bus.busy    = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with PWM_BITS=8 and RAMP_PERIOD=4.
module tb_led_fade_pwm;
  localparam int PB = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  led_fade_if #(.PWM_BITS(PB)) bus ();

  led_fade_pwm #(.PWM_BITS(PB), .RAMP_PERIOD(RP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.led_in = 1'b1; bus.enable = 1'b1; bus.max_duty = 8'd8;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.led_out !== 1'b0 || bus.duty !== 8'd0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset: led_out=%b duty=%0d busy=%b, required 0/0/0", bus.led_out, bus.duty, bus.busy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fade_up();
    int hi;
    tick();
    n_vec++;
    if (bus.busy !== 1'b1 || bus.duty !== 8'd0) begin
      n_err++;
      $display("FAIL fade_up_enter: busy=%b duty=%0d, required 1/0", bus.busy, bus.duty);
    end
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < RP - 1; j++) tick();
      n_vec++;
      if (bus.duty !== 8'(k - 1)) begin
        n_err++;
        $display("FAIL fade_up_hold: duty=%0d, required %0d", bus.duty, k - 1);
      end
      tick();
      n_vec++;
      if (bus.duty !== 8'(k)) begin
        n_err++;
        $display("FAIL fade_up_step: duty=%0d, required %0d", bus.duty, k);
      end
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL fade_up_done: busy=%b, required 0", bus.busy);
    end
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (bus.led_out === 1'b1) hi++;
    end
    n_vec++;
    if (hi != 8) begin
      n_err++;
      $display("FAIL fade_up_pwm: high cycles=%0d, required 8", hi);
    end
  endtask

  task automatic test_reversal();
    int hi;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.led_in = 1'b1; bus.enable = 1'b1; bus.max_duty = 8'd8;
    tick();
    for (int i = 0; i < 5 * RP; i++) tick();
    n_vec++;
    if (bus.duty !== 8'd5 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rev_peak: duty=%0d busy=%b, required 5/1", bus.duty, bus.busy);
    end
    bus.led_in = 1'b0;
    tick();
    n_vec++;
    if (bus.duty !== 8'd5 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rev_enter: duty=%0d busy=%b, required 5/1", bus.duty, bus.busy);
    end
    for (int k = 4; k >= 0; k--) begin
      for (int j = 0; j < RP; j++) tick();
      n_vec++;
      if (bus.duty !== 8'(k)) begin
        n_err++;
        $display("FAIL rev_step: duty=%0d, required %0d", bus.duty, k);
      end
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rev_off: busy=%b, required 0", bus.busy);
    end
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (bus.led_out !== 1'b0) hi++;
    end
    n_vec++;
    if (hi != 0) begin
      n_err++;
      $display("FAIL rev_dark: high cycles=%0d, required 0", hi);
    end
  endtask

  task automatic test_live_brightness();
    bus.max_duty = 8'd200; bus.led_in = 1'b1; bus.enable = 1'b1;
    tick();
    for (int i = 0; i < 200 * RP; i++) tick();
    n_vec++;
    if (bus.duty !== 8'd200 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL live_on: duty=%0d busy=%b, required 200/0", bus.duty, bus.busy);
    end
    bus.max_duty = 8'd50;
    tick();
    n_vec++;
    if (bus.duty !== 8'd50) begin
      n_err++;
      $display("FAIL live_change: duty=%0d, required 50", bus.duty);
    end
    bus.enable = 1'b0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b1 || bus.duty !== 8'd50) begin
      n_err++;
      $display("FAIL live_down_enter: busy=%b duty=%0d, required 1/50", bus.busy, bus.duty);
    end
    for (int i = 0; i < 200 - 1; i++) tick();
    n_vec++;
    if (bus.duty !== 8'd1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL live_down_last: duty=%0d busy=%b, required 1/1", bus.duty, bus.busy);
    end
    tick();
    n_vec++;
    if (bus.duty !== 8'd0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL live_down_off: duty=%0d busy=%b, required 0/0", bus.duty, bus.busy);
    end
  endtask

  task automatic test_extremes();
    int hi;
    bus.max_duty = 8'd0; bus.enable = 1'b1; bus.led_in = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.duty !== 8'd0) begin
      n_err++;
      $display("FAIL zero_on: busy=%b duty=%0d, required 0/0", bus.busy, bus.duty);
    end
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (bus.led_out !== 1'b0) hi++;
    end
    n_vec++;
    if (hi != 0) begin
      n_err++;
      $display("FAIL zero_pwm: high cycles=%0d, required 0", hi);
    end
    bus.max_duty = 8'd255;
    tick();
    n_vec++;
    if (bus.duty !== 8'd255) begin
      n_err++;
      $display("FAIL full_duty: duty=%0d, required 255", bus.duty);
    end
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (bus.led_out === 1'b1) hi++;
    end
    n_vec++;
    if (hi != 255) begin
      n_err++;
      $display("FAIL full_pwm: high cycles=%0d, required 255", hi);
    end
  endtask

  task automatic test_reset_mid_ramp();
    bus.max_duty = 8'd3;
    tick();
    bus.led_in = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.busy !== 1'b1 || bus.duty !== 8'd3) begin
      n_err++;
      $display("FAIL mid_ramp: busy=%b duty=%0d, required 1/3", bus.busy, bus.duty);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.duty !== 8'd0 || bus.led_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b duty=%0d led_out=%b, required 0/0/0", bus.busy, bus.duty, bus.led_out);
    end
    rst = 1'b0;
    bus.led_in = 1'b1; bus.max_duty = 8'd0;
    // Edge n after the reset edge sees pwm_cnt=n-1, so the single dark slot lands on edge 256.
    for (int n = 1; n <= 257; n++) begin
      tick();
      if (n == 2) bus.max_duty = 8'd255;
      if (n == 255 || n == 256 || n == 257) begin
        n_vec++;
        if (bus.led_out !== ((n == 256) ? 1'b0 : 1'b1)) begin
          n_err++;
          $display("FAIL cnt_restart: edge %0d led_out=%b, required %b", n, bus.led_out, (n == 256) ? 1'b0 : 1'b1);
        end
      end
    end
  endtask

  initial begin
    bus.led_in = 1'b0; bus.enable = 1'b0; bus.max_duty = '0;
    test_reset();
    test_fade_up();
    test_reversal();
    test_live_brightness();
    test_extremes();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
